// File: rtl/uart_pkg.sv
// Shared 8N1 UART definitions: FSM state encodings, frame width and line levels.
// Used by both the receiver and the transmitter.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  localparam logic UART_START_LVL = 1'b0;
  localparam logic UART_STOP_LVL  = 1'b1;
  localparam logic UART_IDLE_LVL  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } uart_state_e;

endpackage

// File: rtl/uart_tick_edge.sv
// Rising-edge detector for the oversample tick.
// rise_o is combinational from level_i and its registered copy.
module uart_tick_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic level_i,
  output logic rise_o
);

  logic level_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level_i;
    end
  end

  assign rise_o = level_i & ~level_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, stop-bit check and break holdoff.
// Define UART_RX_SYNC_EN to pass d_in through a 2-flop synchronizer first.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      d_in,
  input  logic                      baud_tick,
  output logic [UART_DATA_BITS-1:0] data_out,
  output logic                      r_valid,
  output logic                      frame_err,
  output logic                      r_busy
);

  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] HALF_LAST = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0] FULL_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [2:0]      LAST_BIT  = 3'(UART_DATA_BITS - 1);

  logic tick;
  logic line;

  uart_state_e                 state_q, state_d;
  logic [OS_W-1:0]             os_cnt_q, os_cnt_d;
  logic [2:0]                  bit_cnt_q, bit_cnt_d;
  logic [UART_DATA_BITS-1:0]   shift_q, shift_d;
  logic [UART_DATA_BITS-1:0]   data_q, data_d;
  logic                        valid_q, valid_d;
  logic                        ferr_q, ferr_d;
  logic                        busy_q, busy_d;

  uart_tick_edge u_tick_edge (
    .clk_i   (clk),
    .rst_i   (rst),
    .level_i (baud_tick),
    .rise_o  (tick)
  );

`ifdef UART_RX_SYNC_EN
  logic sync1_q, sync2_q;

  // Reset to the idle level so leaving reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= UART_IDLE_LVL;
      sync2_q <= UART_IDLE_LVL;
    end else begin
      sync1_q <= d_in;
      sync2_q <= sync1_q;
    end
  end

  assign line = sync2_q;
`else
  assign line = d_in;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      os_cnt_q  <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      os_cnt_q  <= os_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      busy_q    <= busy_d;
    end
  end

  // Everything advances on tick only; strobes default low so they last one cycle.
  always_comb begin
    state_d   = state_q;
    os_cnt_d  = os_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    busy_d    = busy_q;

    if (tick) begin
      unique case (state_q)
        ST_IDLE: begin
          if (line == UART_START_LVL) begin
            state_d  = ST_START;
            os_cnt_d = '0;
            busy_d   = 1'b1;
          end
        end

        ST_START: begin
          if (os_cnt_q == HALF_LAST) begin
            if (line == UART_START_LVL) begin
              state_d   = ST_DATA;
              os_cnt_d  = '0;
              bit_cnt_d = '0;
            end else begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
            end
          end else begin
            os_cnt_d = os_cnt_q + 1'b1;
          end
        end

        ST_DATA: begin
          if (os_cnt_q == FULL_LAST) begin
            shift_d[bit_cnt_q] = line;
            os_cnt_d           = '0;
            bit_cnt_d          = bit_cnt_q + 3'd1;
            if (bit_cnt_q == LAST_BIT) begin
              state_d = ST_STOP;
            end
          end else begin
            os_cnt_d = os_cnt_q + 1'b1;
          end
        end

        // Leaving at mid-stop lets a start edge right after the stop bit be caught.
        ST_STOP: begin
          if (os_cnt_q == FULL_LAST) begin
            os_cnt_d = '0;
            data_d   = shift_q;
            if (line == UART_STOP_LVL) begin
              valid_d = 1'b1;
              state_d = ST_IDLE;
              busy_d  = 1'b0;
            end else begin
              ferr_d  = 1'b1;
              state_d = ST_BREAK;
            end
          end else begin
            os_cnt_d = os_cnt_q + 1'b1;
          end
        end

        ST_BREAK: begin
          if (line == UART_IDLE_LVL) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
        end

        default: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  assign data_out  = data_q;
  assign r_valid   = valid_q;
  assign frame_err = ferr_q;
  assign r_busy    = busy_q;

endmodule
